// File: rtl/elastic_pipe_stage_if.sv
// Handshake bundle for elastic_pipe_stage: upstream valid/data/stall, downstream
// valid/data/stall, flush and occupancy status.
interface elastic_pipe_stage_if #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic          v_i;
    logic [DW-1:0] data_i;
    logic          stall_o;
    logic          v_o;
    logic [DW-1:0] data_o;
    logic          stall_i;
    logic          flush;
    logic [CW-1:0] count;
    logic          almost_full;

    modport slave (
        input  v_i, data_i, stall_i, flush,
        output stall_o, v_o, data_o, count, almost_full
    );

    modport master (
        output v_i, data_i, stall_i, flush,
        input  stall_o, v_o, data_o, count, almost_full
    );
endinterface

// File: rtl/elastic_pipe_stage.sv
// Elastic valid/stall pipeline stage: DEPTH-entry circular buffer with registered
// upstream stall, synchronous flush, occupancy count and almost-full flag.
module elastic_pipe_stage #(
    parameter int unsigned DW       = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned AF_LEVEL = 3
) (
    input logic                 clk,
    input logic                 rst,
    elastic_pipe_stage_if.slave bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full;
    logic          valid;
    logic          push;
    logic          pop;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full  = (count_q == CW'(DEPTH));
    assign valid = (count_q != '0);
    assign push  = bus.v_i & ~full & ~bus.flush;
    assign pop   = valid & ~bus.stall_i & ~bus.flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is reset so data_o is never X, even while v_o is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= bus.data_i;
        end
    end

    assign bus.stall_o     = full;
    assign bus.v_o         = valid;
    assign bus.data_o      = mem_q[rd_ptr_q];
    assign bus.count       = count_q;
    assign bus.almost_full = (count_q >= CW'(AF_LEVEL));

    a_count_bound: assert property (@(posedge clk) disable iff (!rst) count_q <= CW'(DEPTH));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && full));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst) !(pop && !valid));
endmodule
